// File: rtl/poly_envelope_generator.sv
// Multi-channel ADSR envelope generator with rate-based (step per tick) level motion.
// Every channel owns its state and level; all channels share one set of settings.

module poly_envelope_checker #(
    parameter int NUM_CH = 4
) (
    input logic              clk,
    input logic              rst_b,
    input logic [NUM_CH-1:0] busy,
    input logic [NUM_CH-1:0] done
);

    // A finishing channel drops busy on the same edge its done pulse rises.
    a_done_not_busy: assert property (@(posedge clk) disable iff (!rst_b)
        (done & busy) == {NUM_CH{1'b0}});

endmodule

module poly_envelope_generator #(
    parameter int NUM_CH = 4,
    parameter int LVL_W  = 18,
    parameter int STEP_W = 18
) (
    input  logic                    clk,
    input  logic                    rst_b,
    input  logic                    tick,
    input  logic [NUM_CH-1:0]       note_on,
    input  logic [NUM_CH-1:0]       note_off,
    input  logic [LVL_W-1:0]        peak_lvl,
    input  logic [LVL_W-1:0]        sustain_lvl,
    input  logic [STEP_W-1:0]       attack_step,
    input  logic [STEP_W-1:0]       decay_step,
    input  logic [STEP_W-1:0]       release_step,
    output logic [NUM_CH*LVL_W-1:0] level,
    output logic [NUM_CH-1:0]       busy,
    output logic [NUM_CH-1:0]       done
);

    localparam int EXT_W = LVL_W + 1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

    logic [LVL_W-1:0] sus_eff_s;
    logic [EXT_W-1:0] peak_x_s;
    logic [EXT_W-1:0] sus_x_s;
    logic [EXT_W-1:0] att_step_x_s;
    logic [EXT_W-1:0] dec_step_x_s;
    logic [EXT_W-1:0] rel_step_x_s;
    logic             att_zero_s;
    logic             dec_zero_s;
    logic             rel_zero_s;

    // Sustain can never sit above the attack peak.
    always_comb begin
        if (sustain_lvl < peak_lvl) begin
            sus_eff_s = sustain_lvl;
        end else begin
            sus_eff_s = peak_lvl;
        end
    end

    assign peak_x_s     = {1'b0, peak_lvl};
    assign sus_x_s      = {1'b0, sus_eff_s};
    assign att_step_x_s = EXT_W'(attack_step);
    assign dec_step_x_s = EXT_W'(decay_step);
    assign rel_step_x_s = EXT_W'(release_step);
    assign att_zero_s   = (attack_step == {STEP_W{1'b0}});
    assign dec_zero_s   = (decay_step == {STEP_W{1'b0}});
    assign rel_zero_s   = (release_step == {STEP_W{1'b0}});

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
            state_t           state_r;
            logic [LVL_W-1:0] lvl_r;
            logic             busy_r;
            logic             done_r;
            logic [EXT_W-1:0] lvl_x_s;
            logic [EXT_W-1:0] att_sum_s;
            logic [EXT_W-1:0] dec_floor_s;
            logic             att_end_s;
            logic             dec_end_s;
            logic             rel_end_s;
            logic             off_ok_s;

            // Compare in one extra bit so large steps never wrap; level-step <= x
            // is evaluated as level <= x+step to stay unsigned.
            assign lvl_x_s     = {1'b0, lvl_r};
            assign att_sum_s   = lvl_x_s + att_step_x_s;
            assign dec_floor_s = sus_x_s + dec_step_x_s;
            assign att_end_s   = att_zero_s || (lvl_x_s >= peak_x_s) || (att_sum_s >= peak_x_s);
            assign dec_end_s   = dec_zero_s || (lvl_x_s <= dec_floor_s);
            assign rel_end_s   = rel_zero_s || (lvl_x_s <= rel_step_x_s);
            assign off_ok_s    = (state_r == ST_ATTACK) || (state_r == ST_DECAY) ||
                                 (state_r == ST_SUSTAIN);

            // Per-channel envelope FSM: events take precedence over tick updates.
            always_ff @(posedge clk or negedge rst_b) begin
                if (!rst_b) begin
                    state_r <= ST_IDLE;
                    lvl_r   <= {LVL_W{1'b0}};
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end else begin
                    done_r <= 1'b0;
                    if (note_on[g]) begin
                        state_r <= ST_ATTACK;
                        busy_r  <= 1'b1;
                    end else if (note_off[g] && off_ok_s) begin
                        state_r <= ST_RELEASE;
                        busy_r  <= 1'b1;
                    end else if (tick) begin
                        case (state_r)
                            ST_ATTACK: begin
                                if (att_end_s) begin
                                    lvl_r   <= peak_lvl;
                                    state_r <= ST_DECAY;
                                end else begin
                                    lvl_r <= att_sum_s[LVL_W-1:0];
                                end
                            end
                            ST_DECAY: begin
                                if (dec_end_s) begin
                                    lvl_r   <= sus_eff_s;
                                    state_r <= ST_SUSTAIN;
                                end else begin
                                    lvl_r <= lvl_r - LVL_W'(decay_step);
                                end
                            end
                            ST_SUSTAIN: begin
                                lvl_r <= sus_eff_s;
                            end
                            ST_RELEASE: begin
                                if (rel_end_s) begin
                                    lvl_r   <= {LVL_W{1'b0}};
                                    state_r <= ST_IDLE;
                                    busy_r  <= 1'b0;
                                    done_r  <= 1'b1;
                                end else begin
                                    lvl_r <= lvl_r - LVL_W'(release_step);
                                end
                            end
                            ST_IDLE: begin
                                lvl_r <= {LVL_W{1'b0}};
                            end
                            default: begin
                                state_r <= ST_IDLE;
                                lvl_r   <= {LVL_W{1'b0}};
                                busy_r  <= 1'b0;
                            end
                        endcase
                    end else begin
                        state_r <= state_r;
                        lvl_r   <= lvl_r;
                    end
                end
            end

            assign level[g*LVL_W +: LVL_W] = lvl_r;
            assign busy[g]                 = busy_r;
            assign done[g]                 = done_r;
        end
    endgenerate

    poly_envelope_checker #(
        .NUM_CH (NUM_CH)
    ) u_checker (
        .clk   (clk),
        .rst_b (rst_b),
        .busy  (busy),
        .done  (done)
    );

endmodule
